branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage branch resolution for the MIPS datapath.
- Consumes the register operands that feed the 32-bit equality comparator (`equals`, instantiated internally with matching width) and decides taken/not-taken for BEQ/BNE/B.
- Computes the redirect target.
- Presents the result to fetch through a one-deep registered valid/ready stage.
- Keeps saturating branch statistics.

Parameters:
- N, 32, datapath/PC width; also the width of the internal `equals` instance.
- CW, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous kill of the held result
- in_valid  input  1  decode presents a branch-class instruction
- in_ready  output  1  stage can accept this cycle
- in_op  input  2  00 = NOP/pass, 01 = BEQ, 10 = BNE, 11 = B (unconditional)
- in_pc  input  N  PC of the instruction
- in_rs  input  N  first operand
- in_rt  input  N  second operand
- in_imm  input  16  signed word offset
- out_valid  output  1  result held for fetch
- out_ready  input  1  fetch accepts result
- out_taken  output  1  branch taken
- out_target  output  N  next PC
- out_pc  output  N  PC of the resolved instruction
- branch_count  output  CW  accepted ops 01/10/11
- taken_count  output  CW  accepted ops with taken = 1

Behaviour:
- Reset (async, rst = 1): out_valid = 0, out_taken = 0, out_target = 0, out_pc = 0, branch_count = 0, taken_count = 0. All outputs are held while rst is asserted.
- Equality: eq = (in_rs == in_rt), computed combinationally by the `equals` instance.
- Taken by op:
  - 00: taken = 0.
  - 01: taken = eq.
  - 10: taken = ~eq.
  - 11: taken = 1.
- Target arithmetic:
  - pc4 = in_pc + 4, computed modulo 2^N.
  - offset = sign-extend(in_imm) << 2, taken to N bits.
  - If taken, out_target = pc4 + offset (mod 2^N); otherwise out_target = pc4.
  - Wrap-around is silent; no overflow flag.
- Handshake:
  - Accept = in_valid & in_ready.
  - in_ready = ~out_valid | out_ready. This is a combinational pass-through of out_ready, so back-to-back accepts give full throughput.
  - Latency is 1 cycle: a result accepted at edge k is visible on the outputs after edge k.
- Output stage state machine, 2 states:
  - EMPTY (out_valid = 0):
    - Accept → FULL; load the result.
  - FULL (out_valid = 1):
    - out_ready & accept → stay FULL; load the new result.
    - out_ready & no accept → EMPTY.
    - ~out_ready → hold all out_* stable; in_ready = 0.
- Flush:
  - flush = 1 forces the next state to EMPTY and takes priority over accept.
  - An input presented with flush is dropped and not counted.
  - in_ready during flush follows the normal rule; data is discarded regardless.
- Statistics:
  - On each accept with in_op != 00 and flush = 0, branch_count increments; taken_count also increments if taken.
  - Both counters saturate at 2^CW − 1 and never wrap.
  - They are cleared only by rst.
- Async reset mid-operation discards any held result immediately. Counters clear. in_ready goes to 1 combinationally, because out_valid = 0.
- Every out_* value is registered; none is combinational from the in_* inputs.

Test Plan:
- rst pulse, then idle → out_valid = 0, branch_count = 0, in_ready = 1.
- BEQ: in_pc = 0x0000_0100, rs = rt = 0x1234_5678, imm = 0x0003, out_ready = 1 → next cycle out_valid = 1, out_taken = 1, out_target = 0x0000_0110, branch_count = 1, taken_count = 1.
- BNE with equal operands, and with imm = 0xFFFF, pc = 0x0000_0000:
  - Equal operands → not taken, target = 0x0000_0004.
  - Unequal operands, same imm/pc → taken, target = 0x0000_0000.
  - Also cover pc = 0xFFFF_FFFC, op = 11, imm = 0x0001 → target = 0x0000_0004 (wrap).
- Backpressure: hold out_ready = 0 for 3 cycles after an accept → out_* stable, in_ready = 0. Raise out_ready with a new in_valid → new result on the next edge with no bubble.
- Flush asserted while FULL together with in_valid → out_valid = 0 next cycle, counters unchanged.
- Saturation: CW = 2, 5 accepted BEQ-taken ops → branch_count = taken_count = 3. Assert rst mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolution with registered result stage and statistics

// equals - combinational N-bit equality comparator
module equals #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         eq
);
   assign eq = (a == b);
endmodule

// branch_resolve - decides BEQ/BNE/B, computes next PC, holds it for fetch
module branch_resolve #(
   parameter int N  = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_op,
   input  logic [N-1:0]  in_pc,
   input  logic [N-1:0]  in_rs,
   input  logic [N-1:0]  in_rt,
   input  logic [15:0]   in_imm,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_taken,
   output logic [N-1:0]  out_target,
   output logic [N-1:0]  out_pc,
   output logic [CW-1:0] branch_count,
   output logic [CW-1:0] taken_count
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t       state;
   logic         eq;
   logic         taken;
   logic         accept;
   logic [N-1:0] pc4;
   logic [N-1:0] offset;
   logic [N-1:0] target;

   equals #(.N(N)) u_equals (
      .a  (in_rs),
      .b  (in_rt),
      .eq (eq)
   );

   // out_valid is the state flop itself (FULL encodes as 1)
   assign out_valid = (state == FULL);
   assign in_ready  = ~out_valid | out_ready;
   assign accept    = in_valid & in_ready;

   // branch decision and next-PC arithmetic, all modulo 2^N
   always_comb begin
      taken = 1'b0;
      case (in_op)
         2'b00:   taken = 1'b0;
         2'b01:   taken = eq;
         2'b10:   taken = ~eq;
         default: taken = 1'b1;
      endcase
      pc4    = in_pc + N'(4);
      offset = {{(N-18){in_imm[15]}}, in_imm, 2'b00};
      target = taken ? (pc4 + offset) : pc4;
   end

   // output stage: flush empties the stage and wins over any accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         out_taken  <= 1'b0;
         out_target <= '0;
         out_pc     <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state      <= FULL;
                  out_taken  <= taken;
                  out_target <= target;
                  out_pc     <= in_pc;
               end
            end
            FULL: begin
               if (out_ready) begin
                  if (accept) begin
                     out_taken  <= taken;
                     out_target <= target;
                     out_pc     <= in_pc;
                  end else begin
                     state <= EMPTY;
                  end
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // saturating statistics over accepted, unflushed branch-class ops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_count <= '0;
         taken_count  <= '0;
      end else if (accept && !flush && in_op != 2'b00) begin
         if (branch_count != {CW{1'b1}})
            branch_count <= branch_count + 1'b1;
         if (taken && taken_count != {CW{1'b1}})
            taken_count <= taken_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [1:0]  in_op;
   logic [31:0] in_pc;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic [15:0] in_imm;
   logic        out_ready;

   logic        in_ready,   s_in_ready;
   logic        out_valid,  s_out_valid;
   logic        out_taken,  s_out_taken;
   logic [31:0] out_target, s_out_target;
   logic [31:0] out_pc,     s_out_pc;
   logic [15:0] branch_count;
   logic [15:0] taken_count;
   logic [1:0]  s_branch_count;
   logic [1:0]  s_taken_count;

   int n_checks = 0;
   int n_fail   = 0;

   branch_resolve #(.N(32), .CW(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_target(out_target), .out_pc(out_pc),
      .branch_count(branch_count), .taken_count(taken_count)
   );

   branch_resolve #(.N(32), .CW(2)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_op(in_op),
      .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_taken(s_out_taken),
      .out_target(s_out_target), .out_pc(s_out_pc),
      .branch_count(s_branch_count), .taken_count(s_taken_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic tk,
                            input logic [31:0] tgt, input logic [31:0] pc,
                            input int bc, input int tc);
      check({tag, ".valid"},  32'(out_valid),    32'(v));
      check({tag, ".taken"},  32'(out_taken),    32'(tk));
      check({tag, ".target"}, out_target,        tgt);
      check({tag, ".pc"},     out_pc,            pc);
      check({tag, ".bcount"}, 32'(branch_count), 32'(bc));
      check({tag, ".tcount"}, 32'(taken_count),  32'(tc));
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
      in_valid = v;
      in_op    = op;
      in_pc    = pc;
      in_rs    = rs;
      in_rt    = rt;
      in_imm   = imm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 16'h0);
      tick();
      tick();
      check("rst.valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      tick();
      check("idle.valid",  32'(out_valid),    32'd0);
      check("idle.bcount", 32'(branch_count), 32'd0);
      check("idle.ready",  32'(in_ready),     32'd1);

      // taken BEQ: 0x104 + (3<<2) = 0x110
      drive(1'b1, 2'b01, 32'h0000_0100, 32'h1234_5678, 32'h1234_5678, 16'h0003);
      tick();
      check_out("beq", 1'b1, 1'b1, 32'h0000_0110, 32'h0000_0100, 1, 1);

      // BNE with equal operands: not taken, pc+4
      drive(1'b1, 2'b10, 32'h0000_0000, 32'h0000_00AA, 32'h0000_00AA, 16'hFFFF);
      tick();
      check_out("bne_eq", 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 2, 1);

      // BNE unequal: 4 + (-4) = 0
      drive(1'b1, 2'b10, 32'h0000_0000, 32'h0000_00AA, 32'h0000_00AB, 16'hFFFF);
      tick();
      check_out("bne_ne", 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 3, 2);

      // unconditional B with pc wrap: 0xFFFFFFFC + 4 = 0, + 4 = 4
      drive(1'b1, 2'b11, 32'hFFFF_FFFC, 32'h1, 32'h2, 16'h0001);
      tick();
      check_out("b_wrap", 1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_FFFC, 4, 3);
      check("sat4.bcount", 32'(s_branch_count), 32'd3);
      check("sat4.tcount", 32'(s_taken_count),  32'd3);

      // no input with fetch ready: stage drains
      drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 16'h0);
      tick();
      check("drain.valid", 32'(out_valid), 32'd0);
      check("drain.ready", 32'(in_ready),  32'd1);

      // NOP passes through, not counted
      drive(1'b1, 2'b00, 32'h0000_0200, 32'h5, 32'h5, 16'h0010);
      tick();
      check_out("nop", 1'b1, 1'b0, 32'h0000_0204, 32'h0000_0200, 4, 3);

      // BEQ not taken, then backpressure for 3 cycles
      drive(1'b1, 2'b01, 32'h0000_0300, 32'h1, 32'h2, 16'h0005);
      tick();
      check_out("bp_load", 1'b1, 1'b0, 32'h0000_0304, 32'h0000_0300, 5, 3);
      out_ready = 1'b0;
      drive(1'b1, 2'b11, 32'h0000_0400, 32'h0, 32'h0, 16'h0002);
      #1;
      check("bp.ready0", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out("bp_hold", 1'b1, 1'b0, 32'h0000_0304, 32'h0000_0300, 5, 3);
         check("bp.ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp.ready1", 32'(in_ready), 32'd1);
      tick();
      check_out("bp_next", 1'b1, 1'b1, 32'h0000_040C, 32'h0000_0400, 6, 4);

      // flush while FULL with a valid input: dropped, uncounted
      flush = 1'b1;
      drive(1'b1, 2'b01, 32'h0000_0500, 32'h7, 32'h7, 16'h0001);
      tick();
      check("flush.valid",  32'(out_valid),    32'd0);
      check("flush.bcount", 32'(branch_count), 32'd6);
      check("flush.tcount", 32'(taken_count),  32'd4);
      flush = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 16'h0);

      // saturation: fresh reset, five taken BEQs
      rst = 1'b1;
      #1;
      rst = 1'b0;
      check("rst2.bcount", 32'(branch_count), 32'd0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 2'b01, 32'h0000_1000 + 32'(i * 4), 32'h9, 32'h9, 16'h0000);
         tick();
      end
      check("sat.bcount",  32'(s_branch_count), 32'd3);
      check("sat.tcount",  32'(s_taken_count),  32'd3);
      check("full.bcount", 32'(branch_count),   32'd5);
      check("full.tcount", 32'(taken_count),    32'd5);
      check("sat.target",  s_out_target,        32'h0000_1014);

      // async reset mid-stream, sampled before the next edge
      #2;
      rst = 1'b1;
      #1;
      check_out("arst", 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
      check("arst.ready",   32'(in_ready),       32'd1);
      check("arst.sbcount", 32'(s_branch_count), 32'd0);
      check("arst.svalid",  32'(s_out_valid),    32'd0);
      tick();
      check("arst.hold", 32'(out_valid), 32'd0);
      rst = 1'b0;
      drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 16'h0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
